// File: rtl/viterbi_acs_if.sv
// rtl/viterbi_acs_if.sv - symbol in / metric-update out bundle for the Viterbi ACS bank
//
// Purpose: groups the symbol input and update output signals of viterbi_acs_bank.
// Ports (signals):
//   start, in_valid      frame restart and symbol-valid strobes (master -> slave)
//   sym0, sym1           received soft values, SD_W bits each (master -> slave)
//   out_valid            update strobe (slave -> master)
//   pm_out               NS*PM_W path metrics, state s at [s*PM_W +: PM_W]
//   dec_bits             NS survivor decisions, best_state K-1 bits, norm_evt 1 bit
interface viterbi_acs_if #(
    parameter int K    = 3,
    parameter int SD_W = 1,
    parameter int PM_W = 7
);
    localparam int NS = 1 << (K - 1);

    logic                 start;
    logic                 in_valid;
    logic [SD_W-1:0]      sym0;
    logic [SD_W-1:0]      sym1;
    logic                 out_valid;
    logic [NS*PM_W-1:0]   pm_out;
    logic [NS-1:0]        dec_bits;
    logic [K-2:0]         best_state;
    logic                 norm_evt;

    modport master (
        output start, in_valid, sym0, sym1,
        input  out_valid, pm_out, dec_bits, best_state, norm_evt
    );

    modport slave (
        input  start, in_valid, sym0, sym1,
        output out_valid, pm_out, dec_bits, best_state, norm_evt
    );
endinterface

// File: rtl/viterbi_acs_bank.sv
// rtl/viterbi_acs_bank.sv - registered parallel add-compare-select bank for a rate-1/2 Viterbi decoder
//
// Purpose: computes branch metrics from hard/soft symbols and updates all 2^(K-1)
// path metrics once per valid symbol, emitting survivor decisions and the best state.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     viterbi_acs_if.slave: start/in_valid/sym0/sym1 in;
//           out_valid/pm_out/dec_bits/best_state/norm_evt out (all registered)
module viterbi_acs_bank #(
    parameter int K        = 3,
    parameter int G0       = 'b111,
    parameter int G1       = 'b101,
    parameter int SD_W     = 1,
    parameter int PM_W     = 7,
    parameter int INIT_PEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    viterbi_acs_if.slave bus
);
    localparam int NS   = 1 << (K - 1);
    localparam int SW   = K - 1;
    localparam int BM_W = SD_W + 1;
    localparam logic [K-1:0] G0_V = K'(G0);
    localparam logic [K-1:0] G1_V = K'(G1);

    typedef logic [NS-1:0][PM_W-1:0] pm_vec_t;

    function automatic pm_vec_t init_metrics();
        pm_vec_t v;
        for (int s = 0; s < NS; s++) begin
            v[s] = (s == 0) ? '0 : PM_W'(INIT_PEN);
        end
        return v;
    endfunction

    localparam pm_vec_t PM_INIT = init_metrics();

    // Expected bit 1 costs (2^SD_W-1) - sym, which is simply the bitwise inverse.
    function automatic logic [BM_W-1:0] branch_metric(input logic [K-1:0]    label,
                                                      input logic [SD_W-1:0] y0,
                                                      input logic [SD_W-1:0] y1);
        logic [SD_W-1:0] b0;
        logic [SD_W-1:0] b1;
        b0 = (^(label & G0_V)) ? ~y0 : y0;
        b1 = (^(label & G1_V)) ? ~y1 : y1;
        return {1'b0, b0} + {1'b0, b1};
    endfunction

    pm_vec_t         pm_q, pm_d;
    logic [NS-1:0]   dec_q, dec_d;
    logic [SW-1:0]   best_q, best_d;
    logic            out_valid_q, out_valid_d;
    logic            norm_q, norm_d;

    pm_vec_t         pm_base;
    pm_vec_t         pm_new;
    logic [NS-1:0]   dec_new;
    logic [SW-1:0]   best_new;
    logic            all_msb;

    always_comb begin
        logic [SW-1:0]   sv;
        logic [SW-1:0]   p0;
        logic [SW-1:0]   p1;
        logic [PM_W-1:0] m0;
        logic [PM_W-1:0] m1;
        logic [PM_W-1:0] sel;
        logic [PM_W-1:0] min_v;

        // A frame restart feeds the initial metrics straight into this update.
        pm_base  = bus.start ? PM_INIT : pm_q;
        pm_new   = '0;
        dec_new  = '0;
        all_msb  = 1'b1;
        best_new = '0;

        for (int s = 0; s < NS; s++) begin
            sv  = SW'(s);
            // Predecessors share s's low K-2 bits shifted up; masking makes K=2 yield 0/1.
            p0  = SW'((s << 1) & (NS - 1));
            p1  = p0 | SW'(1);
            m0  = pm_base[p0] + PM_W'(branch_metric({sv[SW-1], p0}, bus.sym0, bus.sym1));
            m1  = pm_base[p1] + PM_W'(branch_metric({sv[SW-1], p1}, bus.sym0, bus.sym1));
            if (m1 < m0) begin
                sel        = m1;
                dec_new[s] = 1'b1;
            end else begin
                sel = m0;
            end
            pm_new[s] = sel;
            all_msb   = all_msb & sel[PM_W-1];
        end

        // Every survivor is at least 2^(PM_W-1): subtract that from all of them.
        if (all_msb) begin
            for (int s = 0; s < NS; s++) begin
                pm_new[s][PM_W-1] = 1'b0;
            end
        end

        // Strict compare in ascending order keeps the lowest index on ties.
        min_v = pm_new[0];
        for (int s = 1; s < NS; s++) begin
            if (pm_new[s] < min_v) begin
                min_v    = pm_new[s];
                best_new = SW'(s);
            end
        end
    end

    always_comb begin
        pm_d        = pm_q;
        dec_d       = dec_q;
        best_d      = best_q;
        out_valid_d = 1'b0;
        norm_d      = 1'b0;
        if (bus.in_valid) begin
            pm_d        = pm_new;
            dec_d       = dec_new;
            best_d      = best_new;
            out_valid_d = 1'b1;
            norm_d      = all_msb;
        end else if (bus.start) begin
            pm_d   = PM_INIT;
            best_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q        <= PM_INIT;
            dec_q       <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
            norm_q      <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            dec_q       <= dec_d;
            best_q      <= best_d;
            out_valid_q <= out_valid_d;
            norm_q      <= norm_d;
        end
    end

    assign bus.pm_out     = pm_q;
    assign bus.dec_bits   = dec_q;
    assign bus.best_state = best_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.norm_evt   = norm_q;
endmodule

// File: tb/tb_viterbi_acs_bank.sv
// tb/tb_viterbi_acs_bank.sv - scoreboard bench for viterbi_acs_bank
module tb_viterbi_acs_bank;
    localparam int K     = 3;
    localparam int NS    = 4;
    localparam int PM_W  = 7;
    localparam int SPM_W = 9;

    typedef struct packed {
        logic [NS*PM_W-1:0] pm;
        logic [NS-1:0]      dec;
        logic [K-2:0]       best;
        logic               norm;
    } exp_t;

    typedef struct packed {
        logic [NS*SPM_W-1:0] pm;
        logic [NS-1:0]       dec;
        logic [K-2:0]        best;
        logic                norm;
    } sd_exp_t;

    localparam logic [NS*PM_W-1:0]  RESET_PM    = {7'd16, 7'd16, 7'd16, 7'd0};
    localparam logic [NS*PM_W-1:0]  START_PM    = {7'd17, 7'd2, 7'd17, 7'd0};
    localparam logic [NS*PM_W-1:0]  FOLLOW_PM   = {7'd3, 7'd0, 7'd3, 7'd2};
    localparam logic [NS*SPM_W-1:0] SD_RESET_PM = {9'd64, 9'd64, 9'd64, 9'd0};

    logic clk;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    exp_t    sb_q[$];
    sd_exp_t sd_q[$];

    int            m_pm[NS];
    int            m_off;
    logic [NS-1:0] m_dec;
    logic [K-2:0]  m_best;
    logic          m_norm;

    viterbi_acs_if #(.K(3), .SD_W(1), .PM_W(7)) bus ();
    viterbi_acs_if #(.K(3), .SD_W(3), .PM_W(9)) bus_sd ();

    viterbi_acs_bank #(.K(3), .G0('b111), .G1('b101), .SD_W(1), .PM_W(7), .INIT_PEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    viterbi_acs_bank #(.K(3), .G0('b111), .G1('b101), .SD_W(3), .PM_W(9), .INIT_PEN(64)) dut_sd (
        .clk(clk), .rst_n(rst_n), .bus(bus_sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_init();
        for (int s = 0; s < NS; s++) m_pm[s] = (s == 0) ? 0 : 16;
        m_off = 0;
    endfunction

    // Forward trellis: every (state, input) pair emits a branch into its successor.
    function automatic void model_update(input int y0, input int y1);
        int         nxt[NS];
        bit         seen[NS];
        int         ns, e0, e1, cand, mn;
        logic [2:0] enc;
        for (int s = 0; s < NS; s++) begin
            nxt[s]  = 0;
            seen[s] = 1'b0;
        end
        for (int p = 0; p < NS; p++) begin
            for (int u = 0; u < 2; u++) begin
                ns   = (u << 1) | (p >> 1);
                enc  = 3'(u * 4 + p);
                e0   = ^(enc & 3'b111);
                e1   = ^(enc & 3'b101);
                cand = m_pm[p] + (e0 != 0 ? 1 - y0 : y0) + (e1 != 0 ? 1 - y1 : y1);
                if (!seen[ns] || cand < nxt[ns]) begin
                    nxt[ns]   = cand;
                    m_dec[ns] = 1'(p & 1);
                    seen[ns]  = 1'b1;
                end
            end
        end
        m_pm   = nxt;
        m_best = '0;
        mn     = m_pm[0];
        for (int s = 1; s < NS; s++) begin
            if (m_pm[s] < mn) begin
                mn     = m_pm[s];
                m_best = 2'(s);
            end
        end
        m_norm = 1'b1;
        for (int s = 0; s < NS; s++) if (m_pm[s] - m_off < 64) m_norm = 1'b0;
        if (m_norm) m_off += 64;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        for (int s = 0; s < NS; s++) e.pm[s*PM_W +: PM_W] = 7'(m_pm[s] - m_off);
        e.dec  = m_dec;
        e.best = m_best;
        e.norm = m_norm;
        return e;
    endfunction

    task automatic drive(input logic st, input logic iv, input int y0, input int y1);
        bus.start    = st;
        bus.in_valid = iv;
        bus.sym0     = 1'(y0);
        bus.sym1     = 1'(y1);
        if (st) model_init();
        if (iv) begin
            model_update(y0, y1);
            sb_q.push_back(model_expect());
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.sym0 = '0; bus.sym1 = '0;
        bus_sd.start = 1'b0; bus_sd.in_valid = 1'b0; bus_sd.sym0 = '0; bus_sd.sym1 = '0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        n_run++; if (bus.pm_out !== RESET_PM) begin n_fail++; $display("FAIL reset_pm: got %h expected %h", bus.pm_out, RESET_PM); end
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_run++; if (bus.dec_bits !== 4'b0000) begin n_fail++; $display("FAIL reset_dec: got %b expected 0000", bus.dec_bits); end
        n_run++; if (bus.best_state !== 2'd0) begin n_fail++; $display("FAIL reset_best: got %0d expected 0", bus.best_state); end
        n_run++; if (bus_sd.pm_out !== SD_RESET_PM) begin n_fail++; $display("FAIL reset_sd_pm: got %h expected %h", bus_sd.pm_out, SD_RESET_PM); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1, 0);
        e = sb_q.pop_front();
        got = {bus.pm_out, bus.dec_bits, bus.best_state, bus.norm_evt};
        n_run++; if (bus.out_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL pre_reset_update: got v=%b %h expected v=1 %h", bus.out_valid, got, e); end
        // Update in flight when reset hits: outputs must clear with no clock edge.
        bus.in_valid = 1'b1; bus.sym0 = 1'b1; bus.sym1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_run++; if (bus.pm_out !== RESET_PM) begin n_fail++; $display("FAIL midreset_pm: got %h expected %h", bus.pm_out, RESET_PM); end
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", bus.out_valid); end
        n_run++; if (bus.dec_bits !== 4'b0000) begin n_fail++; $display("FAIL midreset_dec: got %b expected 0000", bus.dec_bits); end
        n_run++; if (bus.best_state !== 2'd0) begin n_fail++; $display("FAIL midreset_best: got %0d expected 0", bus.best_state); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", bus.out_valid); end
        model_init();
    endtask

    task automatic test_frame_start();
        exp_t e, got;
        drive(1'b1, 1'b1, 0, 0);
        got = {bus.pm_out, bus.dec_bits, bus.best_state, bus.norm_evt};
        n_run++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL start_sb: got empty queue expected one entry"); end
        else begin
            e = sb_q.pop_front();
            if (bus.out_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL start_sb: got v=%b %h expected v=1 %h", bus.out_valid, got, e); end
        end
        n_run++; if (bus.pm_out !== START_PM) begin n_fail++; $display("FAIL start_pm: got %h expected %h", bus.pm_out, START_PM); end
        n_run++; if (bus.dec_bits !== 4'b0000 || bus.best_state !== 2'd0) begin n_fail++; $display("FAIL start_dec_best: got %b/%0d expected 0000/0", bus.dec_bits, bus.best_state); end
    endtask

    task automatic test_follow_on();
        exp_t e, got;
        drive(1'b0, 1'b1, 1, 1);
        got = {bus.pm_out, bus.dec_bits, bus.best_state, bus.norm_evt};
        n_run++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL follow_sb: got empty queue expected one entry"); end
        else begin
            e = sb_q.pop_front();
            if (bus.out_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL follow_sb: got v=%b %h expected v=1 %h", bus.out_valid, got, e); end
        end
        n_run++; if (bus.pm_out !== FOLLOW_PM) begin n_fail++; $display("FAIL follow_pm: got %h expected %h", bus.pm_out, FOLLOW_PM); end
        n_run++; if (bus.best_state !== 2'd2 || bus.dec_bits !== 4'b0000 || bus.norm_evt !== 1'b0) begin
            n_fail++; $display("FAIL follow_misc: got best=%0d dec=%b norm=%b expected 2/0000/0", bus.best_state, bus.dec_bits, bus.norm_evt); end
    endtask

    task automatic test_gaps_restart();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1, 0);
            n_run++;
            if (bus.out_valid !== 1'b0 || bus.pm_out !== FOLLOW_PM || bus.dec_bits !== 4'b0000 || bus.best_state !== 2'd2) begin
                n_fail++; $display("FAIL gap_hold: got v=%b pm=%h dec=%b best=%0d expected v=0 pm=%h dec=0000 best=2",
                                   bus.out_valid, bus.pm_out, bus.dec_bits, bus.best_state, FOLLOW_PM); end
        end
        drive(1'b1, 1'b0, 0, 0);
        n_run++; if (bus.pm_out !== RESET_PM) begin n_fail++; $display("FAIL restart_pm: got %h expected %h", bus.pm_out, RESET_PM); end
        n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_normalisation();
        exp_t e, got;
        bit   seen_norm = 1'b0;
        bit   done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            drive(i == 0, 1'b1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            got = {bus.pm_out, bus.dec_bits, bus.best_state, bus.norm_evt};
            n_run++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL norm_sb: got empty queue expected one entry"); end
            else begin
                e = sb_q.pop_front();
                if (bus.out_valid !== 1'b1 || got !== e) begin
                    n_fail++; $display("FAIL norm_sb step %0d: got v=%b %h expected v=1 %h", i, bus.out_valid, got, e); end
                if (seen_norm) begin
                    done = 1'b1;
                    n_run++; if (bus.norm_evt !== 1'b0) begin n_fail++; $display("FAIL norm_after: got %b expected 0", bus.norm_evt); end
                end else if (e.norm) begin
                    seen_norm = 1'b1;
                    n_run++; if (bus.norm_evt !== 1'b1) begin n_fail++; $display("FAIL norm_evt: got %b expected 1", bus.norm_evt); end
                end
            end
        end
        n_run++; if (!done) begin n_fail++; $display("FAIL norm_reached: got seen=%b expected normalisation plus follow-up", seen_norm); end
    endtask

    task automatic test_soft_decision();
        sd_exp_t e, got;
        bus_sd.start = 1'b1; bus_sd.in_valid = 1'b1; bus_sd.sym0 = 3'd7; bus_sd.sym1 = 3'd0;
        sd_q.push_back({9'd64, 9'd7, 9'd64, 9'd7, 4'b1000, 2'd0, 1'b0});
        @(posedge clk);
        #1;
        bus_sd.start = 1'b0; bus_sd.in_valid = 1'b0;
        got = {bus_sd.pm_out, bus_sd.dec_bits, bus_sd.best_state, bus_sd.norm_evt};
        e = sd_q.pop_front();
        n_run++; if (bus_sd.out_valid !== 1'b1) begin n_fail++; $display("FAIL soft_valid: got %b expected 1", bus_sd.out_valid); end
        n_run++; if (got !== e) begin n_fail++; $display("FAIL soft_update: got %h expected %h", got, e); end
        @(posedge clk);
        #1;
        n_run++; if (bus_sd.out_valid !== 1'b0 || bus_sd.pm_out !== e.pm) begin
            n_fail++; $display("FAIL soft_hold: got v=%b pm=%h expected v=0 pm=%h", bus_sd.out_valid, bus_sd.pm_out, e.pm); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_follow_on();
        test_gaps_restart();
        test_normalisation();
        test_soft_decision();
        n_run++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
